// File: rtl/axis_frame_sink_pkg.sv
// rtl/axis_frame_sink_pkg.sv - shared types and constants for the AXI4-Stream frame sink
package axis_frame_sink_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int ERR_EARLY_LAST = 0;
  localparam int ERR_MISS_LAST  = 1;
  localparam int ERR_MID_USER   = 2;
  localparam int ERR_NO_FRAME   = 3;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/axis_frame_sink_crc32_d24.sv
// rtl/axis_frame_sink_crc32_d24.sv - combinational CRC-32 next value for one 24-bit pixel, MSB first
module axis_frame_sink_crc32_d24
  import axis_frame_sink_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [23:0] data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/axis_frame_sink.sv
// rtl/axis_frame_sink.sv - video AXI4-Stream frame structure checker and counters
// Optional CRC-32 frame signature built when AXIS_FRAME_SINK_CRC_EN is defined.
module axis_frame_sink
  import axis_frame_sink_pkg::*;
#(
  parameter int N_x = 1396,
  parameter int N_y = 1396
) (
  input  logic        clkNx,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [23:0] s_axis_tdata,
  input  logic        err_clr,
  output logic        frame_active,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [3:0]  err_flags,
  output logic [31:0] frame_crc
);

  localparam int XW = (N_x > 1) ? $clog2(N_x) : 1;
  localparam int YW = (N_y > 1) ? $clog2(N_y) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(N_x - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(N_y - 1);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          bad;

  logic          beat_start;
  logic          beat_adv;
  logic          beat_line_end;
  logic          beat_final;
  logic [3:0]    err_vec;

  // Per-beat decode; at most one error bit can be set for any beat.
  always_comb begin
    beat_start    = 1'b0;
    beat_adv      = 1'b0;
    beat_line_end = 1'b0;
    beat_final    = 1'b0;
    err_vec       = '0;
    if (s_axis_tvalid) begin
      if (state == IDLE) begin
        if (s_axis_tuser) beat_start = 1'b1;
        else              err_vec[ERR_NO_FRAME] = 1'b1;
      end else if (s_axis_tuser) begin
        beat_start             = 1'b1;
        err_vec[ERR_MID_USER]  = 1'b1;
      end else begin
        beat_adv                = 1'b1;
        beat_line_end           = s_axis_tlast || (x == X_LAST);
        beat_final              = beat_line_end && (y == Y_LAST);
        err_vec[ERR_EARLY_LAST] = s_axis_tlast && (x != X_LAST);
        err_vec[ERR_MISS_LAST]  = !s_axis_tlast && (x == X_LAST);
      end
    end
  end

  always_ff @(posedge clkNx) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      bad          <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (beat_start) begin
        // A restart from ACTIVE taints the new frame as well.
        state        <= ACTIVE;
        frame_active <= 1'b1;
        x            <= XW'(1);
        y            <= '0;
        bad          <= (state == ACTIVE);
      end else if (beat_final) begin
        state        <= IDLE;
        frame_active <= 1'b0;
        frame_done   <= 1'b1;
        frame_cnt    <= frame_cnt + 16'd1;
        frame_err    <= bad | (|err_vec);
        x            <= '0;
        y            <= '0;
        bad          <= 1'b0;
      end else if (beat_line_end) begin
        x   <= '0;
        y   <= y + 1'b1;
        bad <= bad | (|err_vec);
      end else if (beat_adv) begin
        x <= x + 1'b1;
      end
    end
  end

  // A simultaneous error beats err_clr: clear first, then record the new event.
  always_ff @(posedge clkNx) begin
    if (rst) begin
      err_flags <= '0;
      err_cnt   <= '0;
    end else if (|err_vec) begin
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_vec;
      if (err_clr)                err_cnt <= 16'd1;
      else if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end else if (err_clr) begin
      err_flags <= '0;
      err_cnt   <= '0;
    end
  end

`ifdef AXIS_FRAME_SINK_CRC_EN
  logic [31:0] crc_run;
  logic [31:0] crc_seed_nx;
  logic [31:0] crc_cont_nx;
  logic [31:0] frame_crc_q;

  axis_frame_sink_crc32_d24 u_crc_seed (
    .crc_in  (CRC_INIT),
    .data    (s_axis_tdata),
    .crc_out (crc_seed_nx)
  );

  axis_frame_sink_crc32_d24 u_crc_cont (
    .crc_in  (crc_run),
    .data    (s_axis_tdata),
    .crc_out (crc_cont_nx)
  );

  always_ff @(posedge clkNx) begin
    if (rst) begin
      crc_run     <= CRC_INIT;
      frame_crc_q <= '0;
    end else if (beat_start) begin
      crc_run <= crc_seed_nx;
    end else if (beat_adv) begin
      crc_run <= crc_cont_nx;
      if (beat_final) frame_crc_q <= ~crc_cont_nx;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
  assign frame_crc    = '0;
`endif

endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

Receiving end of the video AXI4-Stream produced by the resize path on `clkNx`. Checks the incoming frame structure against the configured geometry, counts frames and framing errors, and reports a per-frame pass/fail with an optional CRC-32 signature. It sits at the `m_axis_*` output of the resizer, as an on-chip monitor or a bench-side scoreboard front end. The stream has no `tready`, so every beat with `tvalid=1` is consumed.

## Interface
- `N_x`, default 1396, pixels per output line; must be ≥ 2.
- `N_y`, default 1396, lines per output frame; must be ≥ 1.
- `clkNx`  in  1  stream clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tvalid`  in  1  beat qualifier.
- `s_axis_tuser`  in  1  start of frame, on the first pixel.
- `s_axis_tlast`  in  1  end of line, on the last pixel of each line.
- `s_axis_tdata`  in  24  RGB pixel.
- `err_clr`  in  1  clears `err_flags` and `err_cnt`.
- `frame_active`  out  1  high while in the ACTIVE state.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `frame_err`  out  1  valid with `frame_done`; 1 if any error occurred in that frame.
- `frame_cnt`  out  16  frames completed; wraps.
- `err_cnt`  out  16  error events; saturates at 0xFFFF.
- `err_flags`  out  4  sticky error bits:
  - [0] early `tlast`
  - [1] missing `tlast`
  - [2] `tuser` in mid-frame
  - [3] beat outside a frame
- `frame_crc`  out  32  signature of the last completed frame.

## Operation
- Only beats with `tvalid=1` are evaluated. Beats with `tvalid=0` are ignored, including their `tuser` and `tlast`.
- Counters: `x` spans 0..N_x-1 and `y` spans 0..N_y-1. Counter width is `$clog2` of the parameter.
- **IDLE state**
  - Beat with `tuser=1`: go to ACTIVE, set x=1, y=0, seed the CRC with this pixel.
  - Beat with `tuser=0`: set flag [3], increment `err_cnt`, stay in IDLE.
- **ACTIVE state**, per beat, in priority order:
  1. `tuser=1`: set flag [2], mark the frame bad, restart the frame at this pixel (x=1, y=0, CRC reseeded).
  2. `tlast=1` with x ≠ N_x-1: set flag [0], mark the frame bad, end the line (x=0, y+1).
  3. x = N_x-1 with `tlast=0`: set flag [1], mark the frame bad, treat the beat as the line end anyway.
  4. Line end on y = N_y-1: pulse `frame_done`, increment `frame_cnt`, latch `frame_err` and `frame_crc`, go to IDLE.
  5. Otherwise: x+1.
- Each flagged beat increments `err_cnt` by 1.
- `err_clr`: clears `err_flags` and `err_cnt`. When an error occurs in the same cycle, the error wins: the flag is set and `err_cnt` becomes 1.
- `frame_cnt` and `frame_crc` are cleared only by `rst`.

## Timing
- All outputs are registered.
- `frame_done`, `frame_err` and `frame_crc` update in the cycle after the final beat is sampled, i.e. 1-cycle latency.
- `err_flags` and `err_cnt` update in the cycle after the offending beat.
- `frame_active` goes high the cycle after the `tuser` beat and low the cycle after the final beat.
- Back-to-back frames are supported: a `tuser` beat in the cycle right after the final beat starts the next frame with no gap.
- Reset values: every output is 0 and the state is IDLE. A mid-frame `rst` discards the partial frame with no `frame_done`.

## Configuration
- `AXIS_FRAME_SINK_CRC_EN` defined:
  - `frame_crc` is a CRC-32 over all pixels of the frame.
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF.
  - `tdata[23:0]` is processed MSB first, one pixel per beat.
- Not defined: no CRC logic is built and `frame_crc` is tied to 0.

## Structure
- Package `axis_frame_sink_pkg` holds:
  - the state enum (IDLE, ACTIVE);
  - the err bit indices (ERR_EARLY_LAST=0, ERR_MISS_LAST=1, ERR_MID_USER=2, ERR_NO_FRAME=3);
  - CRC_POLY and CRC_INIT.
- Sub-module `axis_frame_sink_crc32_d24`: combinational 24-bit-parallel CRC next-value function, instantiated only under `AXIS_FRAME_SINK_CRC_EN`.

## Test plan
All scenarios use N_x=4 and N_y=3.
- **Clean frame:** 12 beats, `tuser` on beat 0, `tlast` on beats 3/7/11, data 0x000001..0x00000C.
  - Expect `frame_done` one cycle after beat 11, `frame_err`=0, `frame_cnt`=1, `err_flags`=0.
  - Expect `frame_crc` equal to the model value (with CRC_EN), or 0 without it.
- **Early `tlast`:** `tlast` on beat 2 instead of 3 on line 0, then two correct lines.
  - Expect flag [0] set, `err_cnt`=1, `frame_done` after the third `tlast`, `frame_err`=1.
- **Mid-frame `tuser`:** `tuser` on beat 5 of a frame, followed by 12 clean beats starting at that beat.
  - Expect flag [2] set, exactly one `frame_done`, `frame_cnt`=1, `err_cnt`=1.
- **Stray beats:** 3 beats with `tuser=0` before any frame.
  - Expect flag [3] set, `err_cnt`=3, `frame_active`=0.
  - Assert `err_clr` together with a fourth stray beat: expect `err_cnt`=1 and flag [3] still set.
- **Gaps and back-to-back:** two frames with `tvalid` toggled every other cycle, and the second `tuser` in the cycle right after the first frame's last beat.
  - Expect 2 `frame_done` pulses, `frame_cnt`=2, identical `frame_crc` for identical data.
  - Assert `rst` at beat 6 of a third frame: expect no `frame_done` and all outputs 0.
